// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched: address/enable sequencer for an in-place radix-2 DIF NTT over N=2^N_LOG points.
// Optional feature macro NTT_SCHED_STALL_EN adds an i_stall input that pauses pair issue.
module ntt_stage_sched #(
  parameter int N_LOG    = 8,
  parameter int PIPE_LAT = 4,
  parameter int AW       = N_LOG
) (
  input  logic             i_clk,
  input  logic             i_reset,
`ifdef NTT_SCHED_STALL_EN
  input  logic             i_stall,
`endif
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_rd_en,
  output logic             o_rd_bank,
  output logic [AW-1:0]    o_rd_addr0,
  output logic [AW-1:0]    o_rd_addr1,
  output logic [N_LOG-2:0] o_tw_addr,
  output logic             o_bf_en,
  input  logic             i_bf_valid,
  output logic             o_wr_en,
  output logic             o_wr_bank,
  output logic [AW-1:0]    o_wr_addr0,
  output logic [AW-1:0]    o_wr_addr1,
  output logic [3:0]       o_stage,
  output logic             o_out_bank,
  output logic             o_err
);

  localparam int KW = N_LOG - 1;
  localparam int DL = PIPE_LAT + 1;
  localparam logic [KW-1:0] K_LAST     = {KW{1'b1}};
  localparam logic [3:0]    STAGE_LAST = 4'(N_LOG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [KW-1:0] r_k;
  logic [3:0]    r_stage;
  logic [DL-1:0] r_dlValid;
  logic [DL-1:0] r_dlBank;
  logic [AW-1:0] r_dlAddr0 [DL];
  logic [AW-1:0] r_dlAddr1 [DL];
  logic          r_err;

  logic          w_stall;
  logic          w_issue;
  logic          w_lastPair;
  logic          w_lastStage;
  logic          w_dlEmpty;
  logic [3:0]    w_dShift;
  logic [KW-1:0] w_posMask;
  logic [KW-1:0] w_pos;
  logic [KW-1:0] w_tw;
  logic [AW-1:0] w_addr0;
  logic [AW-1:0] w_addr1;

`ifdef NTT_SCHED_STALL_EN
  assign w_stall = i_stall;
`else
  assign w_stall = 1'b0;
`endif

  // Butterfly span is 2^dShift; the pair index k gets a zero bit inserted at position dShift.
  assign w_dShift    = STAGE_LAST - r_stage;
  assign w_posMask   = ~({KW{1'b1}} << w_dShift);
  assign w_pos       = r_k & w_posMask;
  assign w_addr0     = (({1'b0, r_k} >> w_dShift) << (w_dShift + 4'd1)) | {1'b0, w_pos};
  assign w_addr1     = w_addr0 | (AW'(1) << w_dShift);
  assign w_tw        = w_pos << r_stage;
  assign w_lastPair  = (r_k == K_LAST);
  assign w_lastStage = (r_stage == STAGE_LAST);
  assign w_dlEmpty   = ~|r_dlValid;
  assign w_issue     = (r_state == S_ISSUE) && !w_stall;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_rd_en     = 1'b0;
    o_rd_addr0  = '0;
    o_rd_addr1  = '0;
    o_tw_addr   = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_nextState = S_ISSUE;
      end
      S_ISSUE: begin
        o_busy = 1'b1;
        if (w_issue) begin
          o_rd_en    = 1'b1;
          o_rd_addr0 = w_addr0;
          o_rd_addr1 = w_addr1;
          o_tw_addr  = w_tw;
          if (w_lastPair) w_nextState = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_dlEmpty) w_nextState = w_lastStage ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Pair counter and stage index; the stage only advances once the previous stage's writes have landed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_k     <= '0;
      r_stage <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_k     <= '0;
            r_stage <= '0;
          end
        end
        S_ISSUE: begin
          if (!w_stall) r_k <= w_lastPair ? '0 : r_k + KW'(1);
        end
        S_DRAIN: begin
          if (w_dlEmpty && !w_lastStage) r_stage <= r_stage + 4'd1;
        end
        S_DONE: r_stage <= '0;
        default: ;
      endcase
    end
  end

  // Write addresses ride along with the read that produced them instead of being recomputed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dlValid <= '0;
      r_dlBank  <= '0;
      for (int i = 0; i < DL; i++) begin
        r_dlAddr0[i] <= '0;
        r_dlAddr1[i] <= '0;
      end
    end else begin
      r_dlValid <= {r_dlValid[DL-2:0], w_issue};
      r_dlBank  <= {r_dlBank[DL-2:0], w_issue & ~r_stage[0]};
      for (int i = DL - 1; i > 0; i--) begin
        r_dlAddr0[i] <= r_dlAddr0[i-1];
        r_dlAddr1[i] <= r_dlAddr1[i-1];
      end
      r_dlAddr0[0] <= w_issue ? w_addr0 : '0;
      r_dlAddr1[0] <= w_issue ? w_addr1 : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if (i_bf_valid != r_dlValid[DL-1]) begin
      r_err <= 1'b1;
    end
  end

  assign o_rd_bank  = r_stage[0];
  assign o_bf_en    = r_dlValid[0];
  assign o_wr_en    = r_dlValid[DL-1];
  assign o_wr_bank  = r_dlBank[DL-1];
  assign o_wr_addr0 = r_dlAddr0[DL-1];
  assign o_wr_addr1 = r_dlAddr1[DL-1];
  assign o_stage    = r_stage;
  assign o_out_bank = ((N_LOG % 2) != 0);
  assign o_err      = r_err;

endmodule
